// File: rtl/alu_op_sequencer.sv
// Issue stage for a combinational ALU: accepts one command, holds it on the ALU
// inputs for SETTLE cycles, registers the result and offers it downstream.
module alu_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int SETTLE = 1,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             busy,
    output logic [CNTW-1:0]  op_count,
    output logic [1:0]       state_dbg
);

    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and in_ready never depends on in_valid.

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       do_accept;
    logic       do_capture;
    logic       do_release;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        do_accept  = 1'b0;
        do_capture = 1'b0;
        do_release = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    do_accept = 1'b1;
                    cnt_nx    = CNT_LOAD;
                    state_nx  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    do_capture = 1'b1;
                    state_nx   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    do_release = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ALU inputs and the last result are deliberately held between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            if (do_accept) begin
                alu_a  <= in_a;
                alu_b  <= in_b;
                alu_op <= in_op;
            end
            if (do_capture) begin
                res_data  <= alu_out;
                res_zero  <= (alu_out == '0);
                res_valid <= 1'b1;
            end
            if (do_release) begin
                res_valid <= 1'b0;
                op_count  <= op_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; three instances (SETTLE/CNTW = 1/4, 3/16, 4/16)
// share one stimulus set, each with an adder as its ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_op = '0;
    logic        res_ready = 1'b0;

    logic        in_ready_w  [3];
    logic        res_valid_w [3];
    logic        res_zero_w  [3];
    logic        busy_w      [3];
    logic [31:0] res_data_w  [3];
    logic [31:0] alu_a_w     [3];
    logic [31:0] alu_b_w     [3];
    logic [31:0] alu_out_w   [3];
    logic [4:0]  alu_op_w    [3];
    logic [15:0] op_count_w  [3];
    logic [1:0]  state_w     [3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam int CW = (g == 0) ? 4 : 16;
        logic [CW-1:0] cnt;
        assign alu_out_w[g]  = alu_a_w[g] + alu_b_w[g];
        assign op_count_w[g] = 16'(cnt);
        alu_op_sequencer #(.WIDTH(32), .OPW(5), .SETTLE(ST), .CNTW(CW)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready_w[g]),
            .in_a     (in_a),
            .in_b     (in_b),
            .in_op    (in_op),
            .alu_a    (alu_a_w[g]),
            .alu_b    (alu_b_w[g]),
            .alu_op   (alu_op_w[g]),
            .alu_out  (alu_out_w[g]),
            .res_valid(res_valid_w[g]),
            .res_ready(res_ready),
            .res_data (res_data_w[g]),
            .res_zero (res_zero_w[g]),
            .busy     (busy_w[g]),
            .op_count (cnt),
            .state_dbg(state_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset pulse; checks the asynchronous clear and in_ready after release.
    task automatic do_reset(input int idx);
        @(posedge clk);
        #3;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready_w[idx]), 32'd0);
        check("rst_alu_a", alu_a_w[idx], 32'd0);
        check("rst_alu_op", 32'(alu_op_w[idx]), 32'd0);
        check("rst_res_data", res_data_w[idx], 32'd0);
        check("rst_res_valid", 32'(res_valid_w[idx]), 32'd0);
        check("rst_op_count", 32'(op_count_w[idx]), 32'd0);
        check("rst_busy", 32'(busy_w[idx]), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_release_ready", 32'(in_ready_w[idx]), 32'd1);
        check("rst_state", 32'(state_w[idx]), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_cnt;

        // Reset then idle
        do_reset(0);
        step();
        check("idle_ready", 32'(in_ready_w[0]), 32'd1);
        check("idle_busy", 32'(busy_w[0]), 32'd0);
        check("idle_zero", 32'(res_zero_w[0]), 32'd0);

        // Basic op, SETTLE=1
        in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2; in_op = 5'd1; res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("basic_alu_a", alu_a_w[0], 32'd2);
        check("basic_alu_op", 32'(alu_op_w[0]), 32'd1);
        check("basic_busy", 32'(busy_w[0]), 32'd1);
        check("basic_ready_low", 32'(in_ready_w[0]), 32'd0);
        check("basic_no_valid_yet", 32'(res_valid_w[0]), 32'd0);
        step();
        check("basic_valid", 32'(res_valid_w[0]), 32'd1);
        check("basic_data", res_data_w[0], 32'd4);
        check("basic_zero", 32'(res_zero_w[0]), 32'd0);
        step();
        check("basic_valid_drop", 32'(res_valid_w[0]), 32'd0);
        check("basic_count", 32'(op_count_w[0]), 32'd1);
        check("basic_data_hold", res_data_w[0], 32'd4);
        check("basic_alu_a_hold", alu_a_w[0], 32'd2);

        // Backpressure, SETTLE=3
        do_reset(1);
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'hFFFF_FFFB; in_op = 5'd0;
        step();
        check("bp_alu_a", alu_a_w[1], 32'd5);
        in_a = 32'd9; in_b = 32'd1;
        for (int c = 1; c < 3; c++) begin
            step();
            check("bp_settle_valid", 32'(res_valid_w[1]), 32'd0);
            check("bp_settle_ready", 32'(in_ready_w[1]), 32'd0);
        end
        step();
        check("bp_valid_rise", 32'(res_valid_w[1]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_hold_valid", 32'(res_valid_w[1]), 32'd1);
            check("bp_hold_data", res_data_w[1], 32'd0);
            check("bp_hold_zero", 32'(res_zero_w[1]), 32'd1);
            check("bp_hold_ready", 32'(in_ready_w[1]), 32'd0);
            check("bp_hold_alu_a", alu_a_w[1], 32'd5);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release_valid", 32'(res_valid_w[1]), 32'd0);
        check("bp_release_ready", 32'(in_ready_w[1]), 32'd1);
        check("bp_release_count", 32'(op_count_w[1]), 32'd1);
        check("bp_no_bypass", alu_a_w[1], 32'd5);
        step();
        check("bp_second_accept", alu_a_w[1], 32'd9);
        check("bp_second_busy", 32'(busy_w[1]), 32'd1);

        // Back-to-back, SETTLE=1: accepts land exactly 3 cycles apart
        do_reset(0);
        in_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 32'(2 * i + 1);
            in_b = 32'(2 * i + 2);
            exp_q.push_back(32'(4 * i + 3));
            step();
            check("b2b_accept", alu_a_w[0], 32'(2 * i + 1));
            step();
            check("b2b_valid", 32'(res_valid_w[0]), 32'd1);
            if (exp_q.size() != 0) check("b2b_data", res_data_w[0], exp_q.pop_front());
            step();
            check("b2b_valid_drop", 32'(res_valid_w[0]), 32'd0);
            check("b2b_ready", 32'(in_ready_w[0]), 32'd1);
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(op_count_w[0]), 32'd4);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort in SETTLE, SETTLE=4: complete one op first so op_count is nonzero
        do_reset(2);
        in_valid = 1'b1; in_a = 32'd10; in_b = 32'd20; res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("abort_pre_valid", 32'(res_valid_w[2]), 32'd1);
        check("abort_pre_data", res_data_w[2], 32'd30);
        step();
        check("abort_pre_count", 32'(op_count_w[2]), 32'd1);
        in_valid = 1'b1; in_a = 32'd7; in_b = 32'd1;
        step();
        in_valid = 1'b0;
        check("abort_accept", alu_a_w[2], 32'd7);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(res_valid_w[2]), 32'd0);
        check("abort_count", 32'(op_count_w[2]), 32'd0);
        check("abort_alu_a", alu_a_w[2], 32'd0);
        check("abort_busy", 32'(busy_w[2]), 32'd0);
        check("abort_ready_in_rst", 32'(in_ready_w[2]), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready_w[2]), 32'd1);
        for (int c = 0; c < 6; c++) begin
            step();
            check("abort_no_result", 32'(res_valid_w[2]), 32'd0);
        end

        // Counter wrap, CNTW=4, 17 operations
        do_reset(0);
        in_valid = 1'b1; res_ready = 1'b1;
        exp_cnt = 4'd0;
        for (int i = 0; i < 17; i++) begin
            in_a = 32'(i);
            in_b = 32'(2 * i);
            step();
            check("wrap_accept", alu_a_w[0], 32'(i));
            step();
            check("wrap_data", res_data_w[0], 32'(3 * i));
            step();
            exp_cnt = exp_cnt + 4'd1;
            check("wrap_count", 32'(op_count_w[0]), 32'(exp_cnt));
        end
        in_valid = 1'b0;
        check("wrap_final", 32'(op_count_w[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the combinational 32-bit ALU (`A`, `B`, `OP[4:0]` in, `OUT[31:0]` out).
- Accepts one operation at a time over a valid/ready handshake and holds the operands and opcode stable on the ALU inputs.
- Waits a programmable settle time, captures the ALU result into a register, and presents it downstream over a second valid/ready handshake.
- Provides the single place where the combinational ALU gets registered timing in the datapath.

Parameters:
WIDTH, 32, operand/result width (matches ALU A/B/OUT)
OPW, 5, opcode width (matches ALU OP)
SETTLE, 1, cycles between driving ALU inputs and capturing OUT; legal range 1..15, 0 illegal
CNTW, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  command valid
in_ready  out  1  sequencer can accept command
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  OPW  ALU opcode
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_op  out  OPW  to ALU OP
alu_out  in  WIDTH  from ALU OUT
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  captured result
res_zero  out  1  res_data == 0
busy  out  1  state != IDLE
op_count  out  CNTW  completed results, wraps

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - State IDLE, settle counter 0.
  - alu_a, alu_b, alu_op, res_data, op_count all 0.
  - res_valid 0, res_zero 0, busy 0.
  - in_ready is forced 0 while rst is high.
- in_ready = (state==IDLE) && !rst. This is a combinational decode of registered state only; no path from in_valid.
- FSM has three states: IDLE, SETTLE, RESP.
- IDLE:
  - On a rising edge with in_valid && in_ready: register in_a/in_b/in_op into alu_a/alu_b/alu_op.
  - Load the counter with SETTLE-1 and go to SETTLE.
  - With in_valid low, remain in IDLE; ALU outputs keep their previous values.
- SETTLE:
  - If counter != 0, decrement.
  - If counter == 0, capture alu_out into res_data, set res_zero = (alu_out==0), set res_valid=1, and go to RESP.
  - Net timing: command accepted at edge k, result captured at edge k+SETTLE, res_valid high from edge k+SETTLE.
- RESP:
  - res_valid stays high, and res_data/res_zero/alu_* stay stable, until an edge with res_ready high.
  - At that edge: res_valid=0, op_count += 1 (wraps at 2^CNTW-1 to 0), state to IDLE.
- Handshake rules:
  - in_valid is ignored in SETTLE and RESP; the upstream must hold its command.
  - res_ready is ignored outside RESP.
  - No bypass: a new command is accepted at earliest the edge after the result handshake. Minimum period is SETTLE+2 cycles per operation.
  - res_ready may be held permanently high; the result is still visible for exactly one cycle.
- alu_a/alu_b/alu_op are not cleared after completion. They hold the last command until the next accept (keeps ALU inputs quiet).
- res_data/res_zero hold their last values after the handshake until the next capture.
- Reset mid-operation (SETTLE or RESP): the operation is aborted, no result is delivered, and op_count returns to 0. After rst falls, in_ready is 1 in the first cycle.
- SETTLE out of range: elaboration-time check ($error or equivalent) if SETTLE < 1 or SETTLE > 15.
- All arithmetic is the ALU's; the sequencer performs no width changes. op_count is unsigned and wraps modulo 2^CNTW.

Test Plan:
All scenarios use a bench ALU model with alu_out = alu_a + alu_b (combinational).
- Reset then idle: rst pulse mid-cycle, no in_valid -> all outputs 0, in_ready=1 after rst falls, busy=0.
- Basic op, SETTLE=1: in_a=2, in_b=2, in_op=1, in_valid one cycle, res_ready=1 -> alu_a=2/alu_op=1 after accept edge; res_valid high exactly one cycle at accept+1; res_data=4, res_zero=0; op_count=1.
- Backpressure: SETTLE=3, in_a=5, in_b=0xFFFFFFFB, res_ready held low 10 cycles -> res_valid rises at accept+3, res_data=0 and res_zero=1 held stable 10 cycles; in_ready=0 throughout; a second in_valid is ignored until the edge after res_ready.
- Back-to-back: 4 commands with in_valid held high, res_ready=1, SETTLE=1 -> accepts spaced exactly 3 cycles apart; results 3,7,11,15 delivered in order; op_count=4.
- Abort: rst asserted while in SETTLE (SETTLE=4, 2 cycles after accept) -> res_valid never asserts, op_count=0, alu_a=0, in_ready=1 the cycle after rst deasserts.
- Counter wrap: CNTW=4, 17 ops -> op_count sequence reaches 15 then 0 then 1.
